// File: rtl/riio_bias_seq_ctrl.sv
// Power-up sequencer for the EG1D80V bias/bandgap cell: ordered enable, startup pulse, VBIAS.
// Optional restart on failure is built only when RIIO_BIAS_SEQ_RETRY_EN is defined.
module riio_bias_seq_ctrl #(
  parameter int unsigned STARTUP_CYC = 4,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned RETRY_MAX   = 2
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       REQ_I,
  input  logic [3:0] TRIM_BIAS_CFG_I,
  input  logic [4:0] TRIM_CURV_CFG_I,
  input  logic [4:0] TRIM_VBG_CFG_I,
  input  logic       BG_VALID_N_I,
  output logic       EN_O,
  output logic       BG_STARTUP_O,
  output logic       EN_VBIAS_O,
  output logic [3:0] TRIM_BIAS_O,
  output logic [4:0] TRIM_CURV_O,
  output logic [4:0] TRIM_VBG_O,
  output logic       READY_O,
  output logic       FAULT_O,
  output logic [2:0] STATE_O
);

  typedef enum logic [2:0] {
    StOff       = 3'd0,
    StStartup   = 3'd1,
    StSettle    = 3'd2,
    StWaitValid = 3'd3,
    StReady     = 3'd4,
    StShutdown  = 3'd5,
    StFault     = 3'd6
  } state_e;

  localparam int unsigned CntMax0 = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
  localparam int unsigned CntMax  = (CntMax0 > TIMEOUT_CYC) ? CntMax0 : TIMEOUT_CYC;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] StartupLoad = CntW'(STARTUP_CYC - 1);
  localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYC - 1);

  // Valid flag is asynchronous to CLK_I; reset value means "not valid".
  logic valid_n_s1_q, valid_n_s2_q;
  logic bg_valid;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      valid_n_s1_q <= 1'b1;
      valid_n_s2_q <= 1'b1;
    end else begin
      valid_n_s1_q <= BG_VALID_N_I;
      valid_n_s2_q <= valid_n_s1_q;
    end
  end

  assign bg_valid = ~valid_n_s2_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fail;

`ifdef RIIO_BIAS_SEQ_RETRY_EN
  localparam int unsigned RetryW0 = $clog2(RETRY_MAX + 1);
  localparam int unsigned RetryW  = (RetryW0 > 0) ? RetryW0 : 1;

  logic [RetryW-1:0] retry_q, retry_d;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail    = 1'b0;
`ifdef RIIO_BIAS_SEQ_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      StOff: begin
`ifdef RIIO_BIAS_SEQ_RETRY_EN
        retry_d = '0;
`endif
        if (REQ_I) begin
          state_d = StStartup;
          cnt_d   = StartupLoad;
        end
      end
      StStartup: begin
        if (!REQ_I) begin
          state_d = StOff;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSettle: begin
        if (!REQ_I) begin
          state_d = StOff;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StWaitValid;
          cnt_d   = TimeoutLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWaitValid: begin
        // Request drop beats valid, valid beats timeout.
        if (!REQ_I) begin
          state_d = StOff;
          cnt_d   = '0;
        end else if (bg_valid) begin
          state_d = StReady;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StReady: begin
        if (!REQ_I) begin
          state_d = StShutdown;
          cnt_d   = '0;
        end else if (!bg_valid) begin
          fail = 1'b1;
        end
      end
      StShutdown: begin
        state_d = StOff;
        cnt_d   = '0;
      end
      StFault: begin
        if (!REQ_I) begin
          state_d = StOff;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase

    if (fail) begin
`ifdef RIIO_BIAS_SEQ_RETRY_EN
      if (32'(retry_q) < RETRY_MAX) begin
        state_d = StStartup;
        cnt_d   = StartupLoad;
        retry_d = retry_q + RetryW'(1);
      end else begin
        state_d = StFault;
        cnt_d   = '0;
      end
`else
      state_d = StFault;
      cnt_d   = '0;
`endif
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as STATE_O.
  logic en_d, startup_d, vbias_d, ready_d, fault_d;

  always_comb begin
    en_d      = 1'b0;
    startup_d = 1'b0;
    vbias_d   = 1'b0;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    unique case (state_d)
      StStartup: begin
        en_d      = 1'b1;
        startup_d = 1'b1;
      end
      StSettle, StWaitValid, StShutdown: begin
        en_d = 1'b1;
      end
      StReady: begin
        en_d    = 1'b1;
        vbias_d = 1'b1;
        ready_d = 1'b1;
      end
      StFault: begin
        fault_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  logic       trim_load;
  logic [3:0] trim_bias_q, trim_bias_d;
  logic [4:0] trim_curv_q, trim_curv_d;
  logic [4:0] trim_vbg_q, trim_vbg_d;

  assign trim_load = (state_q == StOff) && (state_d == StStartup);

  always_comb begin
    trim_bias_d = trim_bias_q;
    trim_curv_d = trim_curv_q;
    trim_vbg_d  = trim_vbg_q;
    if (trim_load) begin
      trim_bias_d = TRIM_BIAS_CFG_I;
      trim_curv_d = TRIM_CURV_CFG_I;
      trim_vbg_d  = TRIM_VBG_CFG_I;
    end
  end

  logic en_q, startup_q, vbias_q, ready_q, fault_q;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      startup_q   <= 1'b0;
      vbias_q     <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      trim_bias_q <= '0;
      trim_curv_q <= '0;
      trim_vbg_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      startup_q   <= startup_d;
      vbias_q     <= vbias_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      trim_bias_q <= trim_bias_d;
      trim_curv_q <= trim_curv_d;
      trim_vbg_q  <= trim_vbg_d;
    end
  end

  assign EN_O         = en_q;
  assign BG_STARTUP_O = startup_q;
  assign EN_VBIAS_O   = vbias_q;
  assign READY_O      = ready_q;
  assign FAULT_O      = fault_q;
  assign TRIM_BIAS_O  = trim_bias_q;
  assign TRIM_CURV_O  = trim_curv_q;
  assign TRIM_VBG_O   = trim_vbg_q;
  assign STATE_O      = state_q;

endmodule

// File: tb/tb_riio_bias_seq_ctrl.sv
// Directed bench for riio_bias_seq_ctrl; inputs driven and outputs sampled on the falling edge.
// Retry scenarios are selected with the same RIIO_BIAS_SEQ_RETRY_EN define as the design.
module tb_riio_bias_seq_ctrl;

  logic       CLK_I;
  logic       RST_N_I;
  logic       REQ_I;
  logic [3:0] TRIM_BIAS_CFG_I;
  logic [4:0] TRIM_CURV_CFG_I;
  logic [4:0] TRIM_VBG_CFG_I;
  logic       BG_VALID_N_I;
  logic       EN_O;
  logic       BG_STARTUP_O;
  logic       EN_VBIAS_O;
  logic [3:0] TRIM_BIAS_O;
  logic [4:0] TRIM_CURV_O;
  logic [4:0] TRIM_VBG_O;
  logic       READY_O;
  logic       FAULT_O;
  logic [2:0] STATE_O;

  int errors = 0;
  int checks = 0;

  riio_bias_seq_ctrl #(
    .STARTUP_CYC(4),
    .SETTLE_CYC (8),
    .TIMEOUT_CYC(16),
    .RETRY_MAX  (2)
  ) dut (
    .CLK_I          (CLK_I),
    .RST_N_I        (RST_N_I),
    .REQ_I          (REQ_I),
    .TRIM_BIAS_CFG_I(TRIM_BIAS_CFG_I),
    .TRIM_CURV_CFG_I(TRIM_CURV_CFG_I),
    .TRIM_VBG_CFG_I (TRIM_VBG_CFG_I),
    .BG_VALID_N_I   (BG_VALID_N_I),
    .EN_O           (EN_O),
    .BG_STARTUP_O   (BG_STARTUP_O),
    .EN_VBIAS_O     (EN_VBIAS_O),
    .TRIM_BIAS_O    (TRIM_BIAS_O),
    .TRIM_CURV_O    (TRIM_CURV_O),
    .TRIM_VBG_O     (TRIM_VBG_O),
    .READY_O        (READY_O),
    .FAULT_O        (FAULT_O),
    .STATE_O        (STATE_O)
  );

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  // Status vector: {STATE_O, EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, FAULT_O}
  logic [7:0] obs;
  assign obs = {STATE_O, EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, FAULT_O};

  task automatic test_reset();
    RST_N_I         = 1'b0;
    REQ_I           = 1'b0;
    BG_VALID_N_I    = 1'b1;
    TRIM_BIAS_CFG_I = 4'h0;
    TRIM_CURV_CFG_I = 5'h00;
    TRIM_VBG_CFG_I  = 5'h00;
    repeat (2) @(negedge CLK_I);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_status got=%h want=%h", obs, 8'h00);
    end
    checks++;
    if ({TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} !== 14'h0) begin
      errors++;
      $display("FAIL reset_trims got=%h want=0", {TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O});
    end
    RST_N_I = 1'b1;
    @(negedge CLK_I);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_reset got=%h want=%h", obs, 8'h00);
    end
  endtask

  task automatic test_nominal();
    logic [2:0] es;
    logic       st, on;
    TRIM_BIAS_CFG_I = 4'h9;
    TRIM_CURV_CFG_I = 5'h13;
    TRIM_VBG_CFG_I  = 5'h0A;
    BG_VALID_N_I    = 1'b1;
    REQ_I           = 1'b1;
    // Iteration k samples the outputs just after rising edge k (edge 0 samples REQ_I).
    for (int k = 0; k <= 17; k++) begin
      @(negedge CLK_I);
      es = (k <= 3) ? 3'd1 : (k <= 11) ? 3'd2 : (k <= 15) ? 3'd3 : 3'd4;
      st = (k <= 3);
      on = (k >= 16);
      checks++;
      if (obs !== {es, 1'b1, st, on, on, 1'b0}) begin
        errors++;
        $display("FAIL nominal_edge%0d got=%h want=%h", k, obs, {es, 1'b1, st, on, on, 1'b0});
      end
      if (k == 13) BG_VALID_N_I = 1'b0;
    end
    checks++;
    if ({TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} !== {4'h9, 5'h13, 5'h0A}) begin
      errors++;
      $display("FAIL nominal_trims got=%h want=%h", {TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
               {4'h9, 5'h13, 5'h0A});
    end
  endtask

  task automatic test_trim_freeze();
    TRIM_VBG_CFG_I  = 5'h15;
    TRIM_BIAS_CFG_I = 4'h3;
    repeat (3) @(negedge CLK_I);
    checks++;
    if ({READY_O, TRIM_BIAS_O, TRIM_VBG_O} !== {1'b1, 4'h9, 5'h0A}) begin
      errors++;
      $display("FAIL trim_freeze got=%h want=%h", {READY_O, TRIM_BIAS_O, TRIM_VBG_O},
               {1'b1, 4'h9, 5'h0A});
    end
  endtask

  task automatic test_ordered_shutdown();
    REQ_I = 1'b0;
    @(negedge CLK_I);
    checks++;
    if (obs !== {3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL shutdown_vbias_first got=%h want=%h", obs, {3'd5, 5'b10000});
    end
    @(negedge CLK_I);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL shutdown_en_off got=%h want=%h", obs, 8'h00);
    end
    REQ_I = 1'b1;
    @(negedge CLK_I);
    checks++;
    if ({STATE_O, TRIM_BIAS_O, TRIM_VBG_O} !== {3'd1, 4'h3, 5'h15}) begin
      errors++;
      $display("FAIL trim_relatch got=%h want=%h", {STATE_O, TRIM_BIAS_O, TRIM_VBG_O},
               {3'd1, 4'h3, 5'h15});
    end
  endtask

  task automatic test_abort_settle();
    // Continues from STARTUP entered by test_ordered_shutdown (after edge 0).
    repeat (4) @(negedge CLK_I);
    checks++;
    if (obs !== {3'd2, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL abort_in_settle got=%h want=%h", obs, {3'd2, 5'b10000});
    end
    REQ_I = 1'b0;
    @(negedge CLK_I);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL abort_to_off got=%h want=%h", obs, 8'h00);
    end
    BG_VALID_N_I = 1'b1;
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic test_timeout();
`ifndef RIIO_BIAS_SEQ_RETRY_EN
    REQ_I = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      @(negedge CLK_I);
      if (k == 27) begin
        checks++;
        if (obs !== {3'd3, 1'b1, 4'b0000}) begin
          errors++;
          $display("FAIL timeout_last_wait got=%h want=%h", obs, {3'd3, 5'b10000});
        end
      end
    end
    checks++;
    if (obs !== {3'd6, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL timeout_fault got=%h want=%h", obs, {3'd6, 5'b00001});
    end
    REQ_I = 1'b0;
    @(negedge CLK_I);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL fault_clear got=%h want=%h", obs, 8'h00);
    end
`else
    int   pulses;
    logic prev;
    logic seen_ready;
    pulses = 0;
    prev   = 1'b0;
    REQ_I  = 1'b1;
    // Three attempts of 28 cycles each; FAULT lands after edge 84.
    for (int k = 0; k <= 90; k++) begin
      @(negedge CLK_I);
      if (BG_STARTUP_O && !prev) pulses++;
      prev = BG_STARTUP_O;
      if (k == 83) begin
        checks++;
        if (obs !== {3'd3, 1'b1, 4'b0000}) begin
          errors++;
          $display("FAIL retry_last_wait got=%h want=%h", obs, {3'd3, 5'b10000});
        end
      end
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL retry_pulse_count got=%0d want=3", pulses);
    end
    checks++;
    if (obs !== {3'd6, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL retry_fault got=%h want=%h", obs, {3'd6, 5'b00001});
    end
    REQ_I = 1'b0;
    @(negedge CLK_I);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL fault_clear got=%h want=%h", obs, 8'h00);
    end
    // Second attempt succeeds: valid asserted in its SETTLE phase.
    pulses     = 0;
    prev       = 1'b0;
    seen_ready = 1'b0;
    REQ_I      = 1'b1;
    for (int k = 0; k <= 70 && !seen_ready; k++) begin
      @(negedge CLK_I);
      if (BG_STARTUP_O && !prev) pulses++;
      prev = BG_STARTUP_O;
      if (k == 33) BG_VALID_N_I = 1'b0;
      if (READY_O) seen_ready = 1'b1;
    end
    checks++;
    if ({seen_ready, FAULT_O, EN_VBIAS_O} !== 3'b101 || pulses !== 2) begin
      errors++;
      $display("FAIL retry_recover got ready=%b fault=%b vbias=%b pulses=%0d want 1 0 1 2",
               seen_ready, FAULT_O, EN_VBIAS_O, pulses);
    end
    REQ_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    BG_VALID_N_I = 1'b1;
    repeat (3) @(negedge CLK_I);
`endif
  endtask

  task automatic test_valid_loss();
    logic seen_ready;
    seen_ready   = 1'b0;
    REQ_I        = 1'b1;
    BG_VALID_N_I = 1'b0;
    for (int k = 0; k < 40 && !seen_ready; k++) begin
      @(negedge CLK_I);
      if (READY_O) seen_ready = 1'b1;
    end
    checks++;
    if (seen_ready !== 1'b1) begin
      errors++;
      $display("FAIL loss_reach_ready got=%b want=1", seen_ready);
    end
    BG_VALID_N_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    checks++;
`ifndef RIIO_BIAS_SEQ_RETRY_EN
    if (obs !== {3'd6, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL loss_to_fault got=%h want=%h", obs, {3'd6, 5'b00001});
    end
`else
    if (obs !== {3'd1, 1'b1, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL loss_to_retry got=%h want=%h", obs, {3'd1, 5'b11000});
    end
`endif
    REQ_I = 1'b0;
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic test_async_reset();
    BG_VALID_N_I = 1'b1;
    REQ_I        = 1'b1;
    repeat (2) @(negedge CLK_I);
    checks++;
    if (obs !== {3'd1, 1'b1, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL pre_reset_startup got=%h want=%h", obs, {3'd1, 5'b11000});
    end
    #2 RST_N_I = 1'b0;
    #1;
    checks++;
    if ({obs, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} !== 22'h0) begin
      errors++;
      $display("FAIL async_reset_clear got=%h want=0", {obs, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O});
    end
    @(negedge CLK_I);
    RST_N_I = 1'b1;
    @(negedge CLK_I);
    checks++;
    if (obs !== {3'd1, 1'b1, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL restart_startup got=%h want=%h", obs, {3'd1, 5'b11000});
    end
    repeat (4) @(negedge CLK_I);
    checks++;
    if (obs !== {3'd2, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL restart_settle got=%h want=%h", obs, {3'd2, 5'b10000});
    end
    REQ_I = 1'b0;
    repeat (2) @(negedge CLK_I);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_trim_freeze();
    test_ordered_shutdown();
    test_abort_settle();
    test_timeout();
    test_valid_loss();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
